// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS32 fetch stage.
package mips_fetch_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Which redirect source, if any, is steering the PC this cycle
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2
  } redir_sel_t;

  localparam logic [31:0] NOP_WORD = 32'h0;

  // Jump outranks branch when both are requested together
  function automatic redir_sel_t select_redirect(input logic jump, input logic branch_taken);
    return jump ? REDIR_JUMP : (branch_taken ? REDIR_BRANCH : REDIR_NONE);
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation: sequential, branch and jump targets,
// redirect selection and instruction-memory range checks.
module pc_next_logic
  import mips_fetch_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int PC_STEP    = 1,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] instr_pc,
  input  logic                branch_taken,
  input  logic signed [15:0]  branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_target,
  output logic [PC_WIDTH-1:0] seq_pc,
  output redir_sel_t          redir_sel,
  output logic [PC_WIDTH-1:0] redir_pc,
  output logic                pc_in_range,
  output logic                seq_in_range,
  output logic                redir_in_range
);

  localparam logic [PC_WIDTH-1:0] STEP  = PC_WIDTH'(PC_STEP);
  // One extra bit so a depth equal to 2^PC_WIDTH still compares correctly
  localparam logic [PC_WIDTH:0]   DEPTH = (PC_WIDTH+1)'(IMEM_DEPTH);

  logic signed [PC_WIDTH-1:0] offset_ext;
  logic [PC_WIDTH-1:0]        branch_pc;
  logic [PC_WIDTH-1:0]        jump_pc;

  function automatic logic in_range(input logic [PC_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH;
  endfunction

  // Branches are relative to the instruction after the branch (no delay slot);
  // jumps keep the upper PC bits of the jump instruction itself.
  assign offset_ext = {{(PC_WIDTH-16){branch_offset[15]}}, branch_offset};
  assign branch_pc  = instr_pc + STEP + $unsigned(offset_ext);
  assign jump_pc    = {instr_pc[PC_WIDTH-1:26], jump_target};
  assign seq_pc     = pc + STEP;

  assign redir_sel      = select_redirect(jump, branch_taken);
  assign redir_pc       = (redir_sel == REDIR_JUMP) ? jump_pc : branch_pc;

  assign pc_in_range    = in_range(pc);
  assign seq_in_range   = in_range(seq_pc);
  assign redir_in_range = in_range(redir_pc);

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS32 fetch stage: PC register, fetch output register with valid/ready
// handshake toward decode, branch/jump redirect and out-of-range halt.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int PC_STEP    = 1,
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pc_out,
  input  logic [31:0]         instr_in,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic signed [15:0]  branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_target,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                out_ready,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_W = PC_WIDTH'(RESET_PC);

  fetch_state_t        state;
  redir_sel_t          redir_sel;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] redir_pc;
  logic                pc_in_range;
  logic                seq_in_range;
  logic                redir_in_range;
  logic                redirect;
  logic                advance;

  pc_next_logic #(
    .PC_WIDTH   (PC_WIDTH),
    .PC_STEP    (PC_STEP),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_pc_next (
    .pc             (pc_out),
    .instr_pc       (instr_pc),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .seq_pc         (seq_pc),
    .redir_sel      (redir_sel),
    .redir_pc       (redir_pc),
    .pc_in_range    (pc_in_range),
    .seq_in_range   (seq_in_range),
    .redir_in_range (redir_in_range)
  );

  assign redirect = (redir_sel != REDIR_NONE);
  // Fetch only when decode can take the new word (or the register is empty)
  assign advance  = !stall && (!instr_valid || out_ready);

  // Fetch FSM, PC register and fetch output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc_out      <= RESET_PC_W;
      instr_out   <= NOP_WORD;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      unique case (state)
        // One idle cycle after reset; redirects are not honoured here
        ST_BOOT: begin
          state  <= pc_in_range ? ST_RUN : ST_HALT;
          halted <= !pc_in_range;
        end
        // Redirect beats stall/backpressure and squashes the word at pc_out
        ST_RUN: begin
          if (redirect) begin
            pc_out      <= redir_pc;
            instr_valid <= 1'b0;
            if (!redir_in_range) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end else if (advance) begin
            instr_out   <= instr_in;
            instr_pc    <= pc_out;
            instr_valid <= 1'b1;
            pc_out      <= seq_pc;
            fetch_count <= fetch_count + 32'd1;
            // The last in-range word is still delivered before halting
            if (!seq_in_range) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
        end
        // Only an in-range redirect can restart fetch; otherwise drain
        ST_HALT: begin
          if (redirect && redir_in_range) begin
            pc_out      <= redir_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            state       <= ST_RUN;
          end else if (out_ready) begin
            instr_valid <= 1'b0;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
